// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud generator widths, reset oversampling
// select and the packed configuration record.
package uart_pkg;

    localparam int DIV_W   = 16;
    localparam int FRAC_W  = 4;
    localparam int OSR_W   = 5;
    localparam int OSR_DEF = 15;

    typedef struct packed {
        logic [DIV_W-1:0]  div_int;
        logic [FRAC_W-1:0] div_frac;
        logic [OSR_W-1:0]  osr;
    } baud_cfg_t;

endpackage

// File: rtl/baud_gen_frac_if.sv
// Configuration and tick bundle of the fractional baud generator.
// master drives enable/configuration and receives ticks; slave is the generator.
interface baud_gen_frac_if #(
    parameter int DIV_W  = uart_pkg::DIV_W,
    parameter int FRAC_W = uart_pkg::FRAC_W,
    parameter int OSR_W  = uart_pkg::OSR_W
);
    import uart_pkg::*;

    logic              en_i;
    logic [DIV_W-1:0]  div_int_i;
    logic [FRAC_W-1:0] div_frac_i;
    logic [OSR_W-1:0]  osr_i;
    logic              cfg_we_i;
    logic              osr_tick_o;
    logic              bit_tick_o;

    modport master (
        output en_i, div_int_i, div_frac_i, osr_i, cfg_we_i,
        input  osr_tick_o, bit_tick_o
    );

    modport slave (
        input  en_i, div_int_i, div_frac_i, osr_i, cfg_we_i,
        output osr_tick_o, bit_tick_o
    );

endinterface

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: adds the fraction on every completed period
// and reports the carry as a one-cycle period extension (ext_o).
// Only built when BAUD_GEN_FRAC_EN is defined.
`ifdef BAUD_GEN_FRAC_EN
module baud_frac_acc #(
    parameter int FRAC_W = uart_pkg::FRAC_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [FRAC_W-1:0] frac_i,
    input  logic              advance_i,
    input  logic              clear_i,
    output logic              ext_o
);
    import uart_pkg::*;

    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   sum;

    // Carry of acc + frac lengthens the current period; clear wins over advance
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, frac_i};
        ext_o = sum[FRAC_W];
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (advance_i) begin
            acc_d = sum[FRAC_W-1:0];
        end
    end

    // Accumulator register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`endif

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: divides clk_i by div + frac/2^FRAC_W into
// single-cycle oversampling ticks and derives a bit tick every osr+1 of them.
// Macro BAUD_GEN_FRAC_EN enables the fractional accumulator; without it every
// period is exactly div cycles and div_frac_i is ignored.
module baud_gen_frac #(
    parameter int DIV_W   = uart_pkg::DIV_W,
    parameter int FRAC_W  = uart_pkg::FRAC_W,
    parameter int OSR_W   = uart_pkg::OSR_W,
    parameter int OSR_DEF = uart_pkg::OSR_DEF
) (
    input  logic           clk_i,
    input  logic           reset_i,
    baud_gen_frac_if.slave bus
);
    import uart_pkg::*;

    localparam logic [DIV_W:0]   CNT_ONE = (DIV_W+1)'(1);
    localparam logic [OSR_W-1:0] OSR_ONE = OSR_W'(1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [OSR_W-1:0] osr_q, osr_d;
    logic [DIV_W:0]   cnt_q, cnt_d;
    logic [OSR_W-1:0] ocnt_q, ocnt_d;
    logic             osr_tick_q, osr_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             ext;
    logic             restart;
    logic             running;
    logic             period_end;
    logic [DIV_W:0]   period;

    // A write or a disable restarts the period; div == 0 stops the generator
    assign restart    = bus.cfg_we_i | ~bus.en_i;
    assign running    = ~restart & (div_q != '0);
    assign period     = {1'b0, div_q} + {{DIV_W{1'b0}}, ext};
    assign period_end = running & (cnt_q == period - CNT_ONE);

`ifdef BAUD_GEN_FRAC_EN
    logic [FRAC_W-1:0] frac_q, frac_d;

    assign frac_d = bus.cfg_we_i ? bus.div_frac_i : frac_q;

    // Stored fraction, loaded together with the rest of the configuration
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            frac_q <= '0;
        end else begin
            frac_q <= frac_d;
        end
    end

    baud_frac_acc #(.FRAC_W(FRAC_W)) u_acc (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .frac_i    (frac_q),
        .advance_i (period_end),
        .clear_i   (restart),
        .ext_o     (ext)
    );
`else
    logic unused_frac;
    assign unused_frac = ^bus.div_frac_i;
    assign ext         = 1'b0;
`endif

    // Next state: configuration write beats disable, which beats a due tick
    always_comb begin
        div_d      = div_q;
        osr_d      = osr_q;
        cnt_d      = cnt_q;
        ocnt_d     = ocnt_q;
        osr_tick_d = 1'b0;
        bit_tick_d = 1'b0;
        if (bus.cfg_we_i) begin
            div_d  = bus.div_int_i;
            osr_d  = bus.osr_i;
            cnt_d  = '0;
            ocnt_d = '0;
        end else if (!running) begin
            cnt_d  = '0;
            ocnt_d = '0;
        end else if (period_end) begin
            cnt_d      = '0;
            osr_tick_d = 1'b1;
            bit_tick_d = (ocnt_q == osr_q);
            ocnt_d     = (ocnt_q == osr_q) ? '0 : ocnt_q + OSR_ONE;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State and registered tick outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q      <= '0;
            osr_q      <= OSR_W'(OSR_DEF);
            cnt_q      <= '0;
            ocnt_q     <= '0;
            osr_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            osr_q      <= osr_d;
            cnt_q      <= cnt_d;
            ocnt_q     <= ocnt_d;
            osr_tick_q <= osr_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign bus.osr_tick_o = osr_tick_q;
    assign bus.bit_tick_o = bit_tick_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed scenarios plus random configuration/enable
// traffic, checked cycle by cycle against a closed-form tick schedule.
`timescale 1ns/1ps
module tb_baud_gen_frac;
    import uart_pkg::*;

    typedef struct packed {
        logic osr;
        logic bt;
    } exp_t;

    logic clk_i = 1'b0;
    logic reset_i;

    always #5 clk_i = ~clk_i;

    baud_gen_frac_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR_W(OSR_W)) bus ();

    baud_gen_frac #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR_W(OSR_W), .OSR_DEF(OSR_DEF)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: after a restart, the k-th tick lands on enabled edge
    // k*div + floor(k*frac / 2^FRAC_W); every (osr+1)-th tick is a bit tick.
    baud_cfg_t   m_cfg;
    int unsigned m_n;
    int unsigned m_k;
    exp_t        exp_q[$];
    logic        last_osr_exp = 1'b0;

    function automatic int unsigned tick_time(int unsigned k);
        int unsigned f;
`ifdef BAUD_GEN_FRAC_EN
        f = int'(m_cfg.div_frac);
`else
        f = 0;
`endif
        return k * int'(m_cfg.div_int) + ((k * f) >> FRAC_W);
    endfunction

    task automatic model_edge();
        exp_t e;
        e = '0;
        if (reset_i) begin
            m_cfg.div_int  = '0;
            m_cfg.div_frac = '0;
            m_cfg.osr      = OSR_W'(OSR_DEF);
            m_n = 0;
            m_k = 0;
        end else if (bus.cfg_we_i) begin
            m_cfg.div_int  = bus.div_int_i;
            m_cfg.div_frac = bus.div_frac_i;
            m_cfg.osr      = bus.osr_i;
            m_n = 0;
            m_k = 0;
        end else if (!bus.en_i || m_cfg.div_int == '0) begin
            m_n = 0;
            m_k = 0;
        end else begin
            m_n++;
            if (m_n == tick_time(m_k + 1)) begin
                m_k++;
                e.osr = 1'b1;
                e.bt  = ((m_k % (int'(m_cfg.osr) + 1)) == 0);
            end
        end
        exp_q.push_back(e);
        last_osr_exp = e.osr;
    endtask

    task automatic check(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, want);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared half a cycle later
    exp_t mon_e;
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("osr_tick", bus.osr_tick_o, mon_e.osr);
            check("bit_tick", bus.bit_tick_o, mon_e.bt);
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk_i);
            model_edge();
            #1;
        end
    endtask

    task automatic write_cfg(input int d, input int f, input int o);
        bus.div_int_i  = DIV_W'(d);
        bus.div_frac_i = FRAC_W'(f);
        bus.osr_i      = OSR_W'(o);
        bus.cfg_we_i   = 1'b1;
        run(1);
        bus.cfg_we_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_i        = 1'b0;
        bus.en_i       = 1'b0;
        bus.div_int_i  = '0;
        bus.div_frac_i = '0;
        bus.osr_i      = '0;
        bus.cfg_we_i   = 1'b0;
        #1 reset_i = 1'b1;
        #1;
        check("reset_osr", bus.osr_tick_o, 1'b0);
        check("reset_bit", bus.bit_tick_o, 1'b0);
        run(3);
        reset_i = 1'b0;

        // Enable held low, then 4-cycle osr ticks and 16-cycle bit ticks
        write_cfg(4, 0, 3);
        run(4);
        bus.en_i = 1'b1;
        run(40);

        // Half fraction: periods alternate 4,5 (72 cycles per 16 ticks)
        write_cfg(4, 8, 3);
        run(80);

        // Disable on the edge where a tick is due, then re-enable
        write_cfg(4, 0, 3);
        run(3);
        bus.en_i = 1'b0;
        run(2);
        bus.en_i = 1'b1;
        run(12);

        // Configuration write on the edge where a tick is due
        write_cfg(4, 0, 3);
        run(3);
        write_cfg(6, 0, 3);
        run(30);

        // Stopped generator, then continuous ticks
        write_cfg(0, 0, 3);
        run(100);
        write_cfg(1, 0, 3);
        run(20);

        // Asynchronous reset while a tick is being presented
        write_cfg(4, 0, 1);
        for (int i = 0; i < 20 && !last_osr_exp; i++) run(1);
        if (!last_osr_exp) begin
            errors++;
            checks++;
            $display("FAIL reset_wait: no tick within 20 cycles");
        end
        reset_i = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_osr", bus.osr_tick_o, 1'b0);
        check("async_reset_bit", bus.bit_tick_o, 1'b0);
        run(2);
        reset_i = 1'b0;
        run(10);
        write_cfg(4, 0, 3);
        run(20);

        // Random configuration writes and enable toggles
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                write_cfg(int'($urandom_range(0, 6)),
                          int'($urandom_range(0, (1 << FRAC_W) - 1)),
                          int'($urandom_range(0, 7)));
            end else begin
                if ($urandom_range(0, 29) == 0) bus.en_i = ~bus.en_i;
                run(1);
            end
        end

        @(negedge clk_i);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised fractional baud-rate generator for the UART core. Divides the system clock by a programmable integer-plus-fraction divisor to produce single-cycle oversampling ticks. A programmable oversampling counter derives a per-bit tick from them. It supersedes the integer-only generator and feeds the RX sampler (`osr_tick_o`) and the TX shifter (`bit_tick_o`).

## Interface
- `DIV_W`, 16, width of the integer divisor.
- `FRAC_W`, 4, width of the fractional divisor; the fraction is `div_frac / 2^FRAC_W`.
- `OSR_W`, 5, width of the oversampling select.
- `OSR_DEF`, 15, reset value of the stored oversampling select (16x).
- `clk_i`  in  1  system clock; the only clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `en_i`  in  1  generator enable; low holds the generator idle and cleared.
- `div_int_i`  in  DIV_W  integer divisor, in clock cycles per osr tick.
- `div_frac_i`  in  FRAC_W  fractional divisor.
- `osr_i`  in  OSR_W  oversampling select; osr ticks per bit = `osr_i + 1`.
- `cfg_we_i`  in  1  latches `div_int_i`, `div_frac_i` and `osr_i` into the stored configuration.
- `osr_tick_o`  out  1  registered single-cycle oversampling tick.
- `bit_tick_o`  out  1  registered single-cycle bit tick, coincident with an `osr_tick_o` pulse.

## Operation
- **Stored configuration.** Registers `div_q`, `frac_q` and `osr_q`. Reset values: 0, 0, `OSR_DEF`.
- **Cycle counter `cnt`** (DIV_W+1 bits).
  - While enabled it increments every cycle.
  - Period of the current tick = `div_q + ext`, where `ext` = carry-out of `acc + frac_q` (FRAC_W+1-bit sum).
  - When `cnt == div_q + ext - 1`: `cnt` returns to 0, `acc` takes the low FRAC_W bits of the sum, and `osr_tick_o` is registered high for one cycle.
  - Over 2^FRAC_W ticks the total is exactly `2^FRAC_W * div_q + frac_q` cycles.
- **Oversampling counter `ocnt`** (OSR_W bits).
  - Advances on each osr tick.
  - On the osr tick where `ocnt == osr_q`: `ocnt` returns to 0 and `bit_tick_o` pulses in the same cycle as `osr_tick_o`.
- **`div_q == 0`.** Generator stopped; no ticks regardless of `en_i`.
- **`div_q == 1`, `frac_q == 0`.** `osr_tick_o` is high every enabled cycle.
- **Disable.** `en_i` low at an edge clears `cnt`, `acc` and `ocnt`, and forces both ticks to 0 at that edge. Re-enabling restarts a full period from zero.
- **`cfg_we_i` high at an edge.**
  - Loads the new configuration.
  - Clears `cnt`, `acc` and `ocnt`.
  - Forces both ticks to 0 at that edge, even if a tick was due.
  - `cfg_we_i` has priority over a simultaneous `en_i` transition and over a pending tick.
- **Reset (asynchronous).** All registers return to reset values immediately, at any point in a period. Both outputs are 0 during and after reset until a full period elapses.

## Timing
- Outputs are registered; no combinational path from any input to any output.
- With `en_i` first sampled high at edge E and stable config, the first `osr_tick_o` is high in the cycle after edge E+div_q-1+ext. With `div_q=4`, `frac_q=0`, the tick is visible after the 4th enabled edge.
- Tick pulses are exactly one cycle wide, except `div_q=1` with no fraction (continuous).
- Configuration changes take effect from the edge after `cfg_we_i`; the first period after the write is a full period.
- `bit_tick_o` never asserts without `osr_tick_o` in the same cycle.

## Configuration
- **`BAUD_GEN_FRAC_EN` defined.** Fractional accumulator present, as described above.
- **`BAUD_GEN_FRAC_EN` undefined.**
  - `div_frac_i` is ignored and `frac_q`/`acc` are not implemented.
  - `ext` is constant 0, so every period is exactly `div_q` cycles.
  - Ports are unchanged.

## Structure
- Shared package `uart_pkg` holds:
  - default widths (`DIV_W`, `FRAC_W`, `OSR_W`) as localparams;
  - `OSR_DEF`;
  - a typedef `baud_cfg_t` packing `div_int`, `div_frac` and `osr`.
- One sub-module: `baud_frac_acc`. It contains the accumulator and `ext` generation, with inputs `frac`, `advance` and `clear`, and output `ext`. It is instantiated only under `BAUD_GEN_FRAC_EN`.

## Test plan
- Reset asserted mid-period with `div=4`, enabled → both outputs 0 immediately. After release, no tick until a full period has elapsed from the restart.
- Write `div=4`, `frac=0`, `osr=3`; hold `en_i` low for 4 cycles → no ticks. Enable → `osr_tick_o` every 4 cycles and `bit_tick_o` every 16 cycles, coincident with the 4th osr tick.
- Write `div=4`, `frac=8` (`FRAC_W=4`), enabled → periods alternate 4,5,4,5. 16 ticks span 72 cycles. With the macro undefined: 64 cycles.
- Drop `en_i` on the cycle before a tick is due → no tick. Re-enable → next tick after a full 4 cycles.
- Assert `cfg_we_i` (`div=6`) on the cycle before a tick is due → no tick at that edge. Next tick exactly 6 cycles later; `ocnt` restarts.
- Write `div=0`, enabled → no ticks for 100 cycles. Write `div=1`, `frac=0` → `osr_tick_o` high every cycle.
